// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared state type, zero-register constant and packed-port helper
//            for regfile_scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int ZERO_REG = 0;

  // LSB position of port `port` inside a packed bus of `width`-bit fields.
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
// Module   : regfile_read_port
// Brief    : One combinational read port with zero/enable gating, busy lookup
//            and optional write forwarding (macro REGFILE_BYPASS_EN).
// Revision : 1.0 - initial release
// ============================================================================
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                  i_ready,
  input  logic                  i_en,
  input  logic [AW-1:0]         i_addr,
  input  logic [NREGS*XLEN-1:0] i_mem,
  input  logic [NREGS-1:0]      i_busy,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [XLEN-1:0]       i_wr_data,
  output logic [XLEN-1:0]       o_data,
  output logic                  o_busy
);

  localparam logic [AW-1:0] c_zero_addr = AW'(ZERO_REG);

  always_comb begin
    o_data = '0;
    o_busy = 1'b0;
    if (i_ready && i_en && (i_addr != c_zero_addr)) begin
      o_data = i_mem[int'(i_addr) * XLEN +: XLEN];
      o_busy = i_busy[i_addr];
`ifdef REGFILE_BYPASS_EN
      // A same-cycle writeback supersedes both the stored value and busy bit.
      if (i_we && (i_wr_addr == i_addr)) begin
        o_data = i_wr_data;
        o_busy = 1'b0;
      end
`endif
    end
  end

`ifndef REGFILE_BYPASS_EN
  logic w_unused;
  assign w_unused = ^{i_we, i_wr_addr, i_wr_data};
`endif

endmodule
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Brief    : Multi-read-port register file with pending-write busy bits and a
//            post-reset clear sequencer. Option macro: REGFILE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ready,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                we,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr
);

  localparam logic [AW-1:0] c_zero_addr = AW'(ZERO_REG);
  localparam logic [AW-1:0] c_last_addr = AW'(NREGS - 1);

  state_e                r_state;
  logic [AW-1:0]         r_clr_cnt;
  logic                  r_ready;
  logic [NREGS-1:0]      r_busy;
  logic [XLEN-1:0]       r_mem [1:NREGS-1];
  logic [NREGS*XLEN-1:0] w_mem_flat;

  // Entry 0 has no storage; it reads as a constant zero.
  assign w_mem_flat[XLEN-1:0] = '0;

  for (genvar i = 1; i < NREGS; i++) begin : g_flat
    assign w_mem_flat[i*XLEN +: XLEN] = r_mem[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= CLEAR;
      r_clr_cnt <= AW'(1);
      r_busy    <= '0;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_mem[r_clr_cnt] <= '0;
          r_clr_cnt        <= r_clr_cnt + AW'(1);
          if (r_clr_cnt == c_last_addr) begin
            r_state <= RUN;
            r_ready <= 1'b1;
          end
        end
        RUN: begin
          if (we && (wr_addr != c_zero_addr)) begin
            r_mem[wr_addr]  <= wr_data;
            r_busy[wr_addr] <= 1'b0;
          end
          // Issue comes after writeback so a new producer keeps the bit set.
          if (iss_en && (iss_addr != c_zero_addr)) begin
            r_busy[iss_addr] <= 1'b1;
          end
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  assign ready = r_ready;

  for (genvar p = 0; p < NRD; p++) begin : g_rd_port
    regfile_read_port #(
      .XLEN (XLEN),
      .NREGS(NREGS),
      .AW   (AW)
    ) u_read_port (
      .i_ready  (r_ready),
      .i_en     (rd_en[p]),
      .i_addr   (rd_addr[port_lsb(p, AW) +: AW]),
      .i_mem    (w_mem_flat),
      .i_busy   (r_busy),
      .i_we     (we),
      .i_wr_addr(wr_addr),
      .i_wr_data(wr_data),
      .o_data   (rd_data[port_lsb(p, XLEN) +: XLEN]),
      .o_busy   (rd_busy[p])
    );
  end

endmodule
`default_nettype wire

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised multi-read-port integer register file with a pending-write scoreboard for the pipelined RISC-V core. After reset it clears itself with an internal sequencer, one entry per cycle. It serves decode-stage operand reads and writeback-stage writes. Per-register busy bits let decode detect RAW hazards against in-flight instructions.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of two, >=4); entry 0 hard-wired to zero
NRD, 2, number of read ports
AW, $clog2(NREGS), address width (derived; not overridden)

Ports:
clk  input  1  clock
rst  input  1  reset
ready  output  1  high once clear sequence done; core must not issue while low
rd_en  input  NRD  per-port read enable
rd_addr  input  NRD*AW  packed read addresses, port p at [p*AW +: AW]
rd_data  output  NRD*XLEN  packed read data, port p at [p*XLEN +: XLEN]
rd_busy  output  NRD  per-port: addressed register has a pending write
we  input  1  writeback write enable
wr_addr  input  AW  write address
wr_data  input  XLEN  write data
iss_en  input  1  instruction issued with destination iss_addr
iss_addr  input  AW  destination to mark busy

Behaviour:
- Reset is synchronous and active-high on clk (rst), as already decided. It forces state CLEAR, clr_cnt=1, busy all 0, ready=0.
- FSM states:
  - CLEAR: each cycle writes 0 to entry clr_cnt, then clr_cnt++. When clr_cnt==NREGS-1 is written, next state is RUN.
  - RUN: terminal until rst.
- CLEAR therefore lasts NREGS-1 cycles after the reset cycle. ready rises on the first RUN cycle.
- rst asserted mid-CLEAR or in RUN restarts CLEAR from entry 1.
- During CLEAR: we and iss_en are ignored, rd_data=0, rd_busy=0.
- Entry 0: never written, never busy; reads of address 0 return 0 and rd_busy=0.
- Reads are combinational, zero latency. For each port p:
  - if !ready, !rd_en[p] or addr==0: rd_data=0, rd_busy=0
  - else rd_data=reg[addr] (subject to bypass, see Optional Feature)
- Write (RUN, we, wr_addr!=0): reg[wr_addr]<=wr_data on the clk edge, and busy[wr_addr]<=0.
- Issue (RUN, iss_en, iss_addr!=0): busy[iss_addr]<=1 on the clk edge.
- Simultaneous we and iss_en to the same nonzero address: data is written and busy ends at 1 (new producer wins).
- Issue to an already-busy register: busy stays 1 (no count; single outstanding producer per register is guaranteed by the core).
- Write to a non-busy register is legal: data is written, busy stays 0.
- All outputs are driven from registered state plus combinational read logic; there are no output registers.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-to-read forwarding. If we && ready && wr_addr==rd_addr[p]!=0 && rd_en[p], then rd_data[p]=wr_data and rd_busy[p]=0 in the same cycle.
- Undefined: rd_data returns the pre-write register contents and rd_busy reflects the stored busy bit. The core must then stall one extra cycle.

Decomposition:
- Package regfile_pkg holds:
  - state enum {CLEAR, RUN}
  - constant ZERO_REG=0
  - function for packed-port slicing
- One sub-module, regfile_read_port, instantiated NRD times via generate. It contains the per-port mux, zero/enable gating, bypass compare and busy lookup.
- Storage, scoreboard and FSM stay in the top module.

Test Plan:
1. rst 1 cycle -> ready=0 for 31 cycles, rises on cycle 32. Then read all addresses with rd_en=1 -> every rd_data=0, rd_busy=0.
2. RUN; we, wr_addr=5, wr_data=0xDEADBEEF; next cycle read port0 addr5, port1 addr0 -> 0xDEADBEEF and 0; write to addr0 -> later read of addr0 still 0.
3. iss_en addr7 -> next cycle rd_busy for addr7=1. we addr7 data 0x12 -> next cycle rd_busy=0, rd_data=0x12.
4. Same cycle iss_en addr9 and we addr9 data 0x55 -> next cycle rd_data=0x55, rd_busy=1.
5. BYPASS_EN: we addr3 data 0xA5A5 while reading addr3 in the same cycle -> rd_data=0xA5A5, rd_busy=0. Without the macro -> old value, stored busy.
6. rst asserted at CLEAR cycle 10, after prior writes -> ready low again for a full 31 cycles; reg5 reads 0 afterwards; a we during CLEAR is ignored.
